vga_tile_engine: RTL and testbench

Parametrised VGA tile-map display engine: generates programmable H/V timing, fetches a tile index from a map RAM and a pixel colour from a tile-pattern RAM through a fixed-latency read pipeline, and drives sync, data-enable and colour outputs aligned to each other. It supports frame-latched hardware scrolling with map wrap-around and frame/line start strobes. It sits between the character/tile RAMs and the VGA connector.

---
 rtl/vga_tile_engine.sv | 176 +++++++++++++++++
 tb/tb_vga_tile_engine.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_tile_engine.sv
// vga_tile_engine
//   Tile-map VGA display engine. Free-running H/V counters produce the
//   raster position. The position is offset by a scroll value that is
//   latched once per frame, then used to fetch a tile index from the map
//   RAM and a colour from the tile-pattern RAM. Sync, data-enable, colour
//   and the frame/line strobes are all delayed to leave on the same edge,
//   five clocks after the counter state they describe.
//
// Ports
//   clk          pixel clock
//   rst          asynchronous reset, active low
//   scroll_x/y   scroll offset in pixels, sampled at each frame boundary
//   map_addr     map RAM address {tile_row, tile_col}
//   map_data     map RAM read data (one-edge latency)
//   pix_addr     pattern RAM address {tile_id, ty, tx}
//   pix_data     pattern RAM read data (one-edge latency)
//   hsync/vsync  sync outputs, active level SYNC_POL
//   de           active-video enable
//   rgb          pixel colour, 0 outside active video
//   frame_start  strobe with pixel (0,0)
//   line_start   strobe with pixel (0,v) of every active line
module vga_tile_engine #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int TILE_LOG2  = 4,
  parameter int MAP_W_LOG2 = 6,
  parameter int MAP_H_LOG2 = 5,
  parameter int TILE_ID_W  = 6,
  parameter int COLOR_W    = 6
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [MAP_W_LOG2+TILE_LOG2-1:0]      scroll_x,
  input  logic [MAP_H_LOG2+TILE_LOG2-1:0]      scroll_y,
  output logic [MAP_H_LOG2+MAP_W_LOG2-1:0]     map_addr,
  input  logic [TILE_ID_W-1:0]                 map_data,
  output logic [TILE_ID_W+2*TILE_LOG2-1:0]     pix_addr,
  input  logic [COLOR_W-1:0]                   pix_data,
  output logic                                 hsync,
  output logic                                 vsync,
  output logic                                 de,
  output logic [COLOR_W-1:0]                   rgb,
  output logic                                 frame_start,
  output logic                                 line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int XW      = MAP_W_LOG2 + TILE_LOG2;
  localparam int YW      = MAP_H_LOG2 + TILE_LOG2;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Map an internal "sync asserted" flag to the pin level.
  function automatic logic sync_level(input logic asserted);
    return asserted ? SYNC_POL : !SYNC_POL;
  endfunction

  logic [HW-1:0]        h_p0;
  logic [VW-1:0]        v_p0;
  logic [XW-1:0]        sx_l;
  logic [YW-1:0]        sy_l;
  logic [XW-1:0]        px_p0;
  logic [YW-1:0]        py_p0;
  logic                 vld_p0;
  logic [3:0]           flg_p0;   // {hs, vs, frame_start, line_start}
  logic                 h_last;
  logic                 v_last;

  logic [TILE_LOG2-1:0] ty_p1, tx_p1, ty_p2, tx_p2;
  logic                 vld_p1, vld_p2, vld_p3, vld_p4;
  logic [3:0]           flg_p1, flg_p2, flg_p3, flg_p4;

  assign h_last = (h_p0 == H_LAST);
  assign v_last = (v_p0 == V_LAST);

  // Truncating adds give map wrap-around for free; truncating h first is
  // harmless because the result is taken modulo 2^XW anyway.
  assign px_p0  = XW'(h_p0) + sx_l;
  assign py_p0  = YW'(v_p0) + sy_l;

  assign vld_p0 = (h_p0 < H_ACT) && (v_p0 < V_ACT);
  assign flg_p0 = {(h_p0 >= HS_BEG) && (h_p0 <= HS_END),
                   (v_p0 >= VS_BEG) && (v_p0 <= VS_END),
                   (h_p0 == '0) && (v_p0 == '0),
                   (h_p0 == '0) && (v_p0 < V_ACT)};

  // Stage 0: raster counters and per-frame scroll latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_p0 <= '0;
      v_p0 <= '0;
      sx_l <= '0;
      sy_l <= '0;
    end else if (h_last) begin
      h_p0 <= '0;
      if (v_last) begin
        v_p0 <= '0;
        sx_l <= scroll_x;
        sy_l <= scroll_y;
      end else begin
        v_p0 <= v_p0 + VW'(1);
      end
    end else begin
      h_p0 <= h_p0 + HW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      map_addr    <= '0;
      ty_p1       <= '0;
      tx_p1       <= '0;
      vld_p1      <= 1'b0;
      flg_p1      <= '0;
      ty_p2       <= '0;
      tx_p2       <= '0;
      vld_p2      <= 1'b0;
      flg_p2      <= '0;
      pix_addr    <= '0;
      vld_p3      <= 1'b0;
      flg_p3      <= '0;
      vld_p4      <= 1'b0;
      flg_p4      <= '0;
      rgb         <= '0;
      de          <= 1'b0;
      hsync       <= sync_level(1'b0);
      vsync       <= sync_level(1'b0);
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      // Stage 1: map address issued
      map_addr    <= {py_p0[YW-1:TILE_LOG2], px_p0[XW-1:TILE_LOG2]};
      ty_p1       <= py_p0[TILE_LOG2-1:0];
      tx_p1       <= px_p0[TILE_LOG2-1:0];
      vld_p1      <= vld_p0;
      flg_p1      <= flg_p0;
      // Stage 2: map RAM read in flight
      ty_p2       <= ty_p1;
      tx_p2       <= tx_p1;
      vld_p2      <= vld_p1;
      flg_p2      <= flg_p1;
      // Stage 3: pattern address issued
      pix_addr    <= {map_data, ty_p2, tx_p2};
      vld_p3      <= vld_p2;
      flg_p3      <= flg_p2;
      // Stage 4: pattern RAM read in flight
      vld_p4      <= vld_p3;
      flg_p4      <= flg_p3;
      // Stage 5: aligned outputs
      rgb         <= vld_p4 ? pix_data : '0;
      de          <= vld_p4;
      hsync       <= sync_level(flg_p4[3]);
      vsync       <= sync_level(flg_p4[2]);
      frame_start <= flg_p4[1];
      line_start  <= flg_p4[0];
    end
  end

endmodule

// File: tb/tb_vga_tile_engine.sv
// Testbench for vga_tile_engine: one instance with default 640x480 timing
// and one with a tiny 14x7 raster, each backed by behavioural RAMs.
module tb_vga_tile_engine;

  logic        clk;
  logic        rst_d, rst_s;
  logic [9:0]  scroll_x_d, scroll_x_s;
  logic [8:0]  scroll_y_d, scroll_y_s;
  logic [10:0] map_addr_d, map_addr_s;
  logic [5:0]  map_data_d, map_data_s;
  logic [13:0] pix_addr_d, pix_addr_s;
  logic [5:0]  pix_data_d, pix_data_s;
  logic        hsync_d, vsync_d, de_d, fs_d, ls_d;
  logic        hsync_s, vsync_s, de_s, fs_s, ls_s;
  logic [5:0]  rgb_d, rgb_s;

  int cyc = 0;
  int ncmp = 0;
  int nfail = 0;
  int bd, bs;
  int ls_cnt, fs_cnt, de_cnt;

  vga_tile_engine dut_d (
    .clk(clk), .rst(rst_d), .scroll_x(scroll_x_d), .scroll_y(scroll_y_d),
    .map_addr(map_addr_d), .map_data(map_data_d),
    .pix_addr(pix_addr_d), .pix_data(pix_data_d),
    .hsync(hsync_d), .vsync(vsync_d), .de(de_d), .rgb(rgb_d),
    .frame_start(fs_d), .line_start(ls_d)
  );

  vga_tile_engine #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
  ) dut_s (
    .clk(clk), .rst(rst_s), .scroll_x(scroll_x_s), .scroll_y(scroll_y_s),
    .map_addr(map_addr_s), .map_data(map_data_s),
    .pix_addr(pix_addr_s), .pix_data(pix_data_s),
    .hsync(hsync_s), .vsync(vsync_s), .de(de_s), .rgb(rgb_s),
    .frame_start(fs_s), .line_start(ls_s)
  );

  // Map RAM content: id = (col + 7*row) mod 64
  function automatic logic [5:0] map_fn(input logic [10:0] a);
    int s;
    s = int'(a[5:0]) + 7 * int'(a[10:6]);
    return 6'(s);
  endfunction

  // Pattern RAM content: (addr*7+3) mod 64, with one special entry
  function automatic logic [5:0] pat_fn(input logic [13:0] a);
    if (a == 14'd2341) return 6'h2A;
    return 6'(int'(a) * 7 + 3);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    map_data_d <= map_fn(map_addr_d);
    pix_data_d <= pat_fn(pix_addr_d);
    map_data_s <= map_fn(map_addr_s);
    pix_data_s <= pat_fn(pix_addr_s);
  end

  task automatic adv(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_d = 1'b0; rst_s = 1'b0;
    scroll_x_d = '0; scroll_y_d = '0;
    scroll_x_s = '0; scroll_y_s = '0;

    // ---------------- default 640x480 instance ----------------
    adv(10);
    chk("rst_hsync", 32'(hsync_d), 1);
    chk("rst_vsync", 32'(vsync_d), 1);
    chk("rst_de", 32'(de_d), 0);
    chk("rst_rgb", 32'(rgb_d), 0);
    chk("rst_map_addr", 32'(map_addr_d), 0);
    chk("rst_pix_addr", 32'(pix_addr_d), 0);
    chk("rst_small_hsync", 32'(hsync_s), 0);

    #2 rst_d = 1'b1;
    bd = cyc;
    adv(bd + 1);   chk("first_map_addr", 32'(map_addr_d), 0);
    adv(bd + 4);   chk("de_before_latency", 32'(de_d), 0);
    adv(bd + 5);
    chk("first_de", 32'(de_d), 1);
    chk("first_frame_start", 32'(fs_d), 1);
    chk("first_line_start", 32'(ls_d), 1);
    chk("first_rgb", 32'(rgb_d), 3);
    chk("first_hsync", 32'(hsync_d), 1);
    adv(bd + 6);
    chk("fs_one_cycle", 32'(fs_d), 0);
    chk("ls_one_cycle", 32'(ls_d), 0);
    adv(bd + 644); chk("de_last_active", 32'(de_d), 1);
    adv(bd + 645); chk("de_first_blank", 32'(de_d), 0);
    adv(bd + 660); chk("hsync_pre", 32'(hsync_d), 1);
    adv(bd + 661); chk("hsync_fall", 32'(hsync_d), 0);
    adv(bd + 756); chk("hsync_last_low", 32'(hsync_d), 0);
    adv(bd + 757); chk("hsync_rise", 32'(hsync_d), 1);
    adv(bd + 805);
    chk("line1_ls", 32'(ls_d), 1);
    chk("line1_fs", 32'(fs_d), 0);
    chk("line1_de", 32'(de_d), 1);
    adv(bd + 1461); chk("hsync_period", 32'(hsync_d), 0);
    // pixel (37,18): tile row 1, col 2, ty 2, tx 5
    adv(bd + 14438); chk("addr_map", 32'(map_addr_d), 32'({5'd1, 6'd2}));
    adv(bd + 14440); chk("addr_pix", 32'(pix_addr_d), 32'({6'd9, 4'd2, 4'd5}));
    adv(bd + 14442);
    chk("addr_rgb", 32'(rgb_d), 32'h2A);
    chk("addr_de", 32'(de_d), 1);

    // ---------------- small 14x7 instance ----------------
    #2 rst_s = 1'b1;
    bs = cyc;
    adv(bs + 5);
    chk("s_first_de", 32'(de_s), 1);
    chk("s_first_fs", 32'(fs_s), 1);
    chk("s_first_ls", 32'(ls_s), 1);
    chk("s_first_rgb", 32'(rgb_s), 3);
    adv(bs + 12); chk("s_de_h7", 32'(de_s), 1);
    adv(bs + 13); chk("s_de_h8", 32'(de_s), 0);
    adv(bs + 14); chk("s_hsync_h9", 32'(hsync_s), 0);
    adv(bs + 15); chk("s_hsync_h10", 32'(hsync_s), 1);
    adv(bs + 16); chk("s_hsync_h11", 32'(hsync_s), 1);
    adv(bs + 17); chk("s_hsync_h12", 32'(hsync_s), 0);
    adv(bs + 29); chk("s_hsync_line1", 32'(hsync_s), 1);
    adv(bs + 61);
    chk("s_de_v4", 32'(de_s), 0);
    chk("s_ls_v4", 32'(ls_s), 0);
    adv(bs + 74); chk("s_vsync_pre", 32'(vsync_s), 0);
    adv(bs + 75); chk("s_vsync_start", 32'(vsync_s), 1);
    adv(bs + 88); chk("s_vsync_end", 32'(vsync_s), 1);
    adv(bs + 89); chk("s_vsync_after", 32'(vsync_s), 0);

    ls_cnt = 0; fs_cnt = 0; de_cnt = 0;
    for (int k = 103; k <= 200; k++) begin
      adv(bs + k);
      if (ls_s) ls_cnt++;
      if (fs_s) fs_cnt++;
      if (de_s) de_cnt++;
    end
    chk("s_ls_per_frame", ls_cnt, 4);
    chk("s_fs_per_frame", fs_cnt, 1);
    chk("s_de_per_frame", de_cnt, 32);

    // scroll change mid-frame must wait for the next frame
    adv(bs + 224); scroll_x_s = 10'd16;
    adv(bs + 228); chk("s_latch_hold", 32'(map_addr_s), 0);
    adv(bs + 295); chk("s_latch_apply", 32'(map_addr_s), 1);

    // wrap-around: 1020 + h and 510 + v
    adv(bs + 300); scroll_x_s = 10'd1020; scroll_y_s = 9'd510;
    adv(bs + 396); chk("s_wrap_map", 32'(map_addr_s), 2047);
    adv(bs + 398); chk("s_wrap_pix", 32'(pix_addr_s), 6383);
    adv(bs + 400);
    chk("s_wrap_rgb", 32'(rgb_s), 12);
    chk("s_wrap_de", 32'(de_s), 1);
    adv(bs + 473); chk("s_wrap2_map", 32'(map_addr_s), 0);
    adv(bs + 475); chk("s_wrap2_pix", 32'(pix_addr_s), 54);
    adv(bs + 477);
    chk("s_pre_rst_hsync", 32'(hsync_s), 1);
    chk("s_pre_rst_vsync", 32'(vsync_s), 1);

    // asynchronous reset mid-line
    #1 rst_s = 1'b0;
    #1;
    chk("s_mid_rst_hsync", 32'(hsync_s), 0);
    chk("s_mid_rst_vsync", 32'(vsync_s), 0);
    chk("s_mid_rst_de", 32'(de_s), 0);
    chk("s_mid_rst_rgb", 32'(rgb_s), 0);
    chk("s_mid_rst_map", 32'(map_addr_s), 0);
    chk("s_mid_rst_pix", 32'(pix_addr_s), 0);
    chk("s_mid_rst_fs", 32'(fs_s), 0);
    chk("s_mid_rst_ls", 32'(ls_s), 0);
    adv(cyc + 3);
    #2 rst_s = 1'b1;
    bs = cyc;
    adv(bs + 1); chk("s_restart_map", 32'(map_addr_s), 0);
    adv(bs + 4); chk("s_restart_de_early", 32'(de_s), 0);
    adv(bs + 5);
    chk("s_restart_de", 32'(de_s), 1);
    chk("s_restart_fs", 32'(fs_s), 1);
    chk("s_restart_ls", 32'(ls_s), 1);
    chk("s_restart_rgb", 32'(rgb_s), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
